video_stim_gen: RTL

VIDEO_STIM_GEN -- requirements
Module: video_stim_gen

---
 rtl/video_stim_gen.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/video_stim_gen.sv
// Frame-timed video test-pattern source: ramp, coordinate, checker or constant pixels with sync strobes.
// Define STIM_GEN_CHKSUM_EN to build the per-frame pixel checksum driven on chkSum.
module video_stim_gen #(
  parameter int DATA_WIDTH  = 16,
  parameter int RES_WIDTH   = 11,
  parameter int BLANK_WIDTH = 8
) (
  input  logic                   clka,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cont,
  input  logic [1:0]             mode,
  input  logic [DATA_WIDTH-1:0]  seed,
  input  logic [RES_WIDTH-1:0]   inXRes,
  input  logic [RES_WIDTH-1:0]   inYRes,
  input  logic [BLANK_WIDTH-1:0] hBlank,
  input  logic [BLANK_WIDTH-1:0] vBlank,
  output logic [DATA_WIDTH-1:0]  dOut,
  output logic                   dOutEn,
  output logic                   oHsyn,
  output logic                   oVsyn,
  output logic                   busy,
  output logic                   frameDone,
  output logic [31:0]            chkSum
);
  // state  | meaning
  // IDLE   | waiting for a start pulse
  // VSYNC  | frame-start strobe, frame config latched
  // PIX    | emitting the pixels of the current row
  // HBLANK | row blanking, oHsyn on its first cycle
  // VBLANK | frame blanking
  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_PIX, S_HBLANK, S_VBLANK} state_t;

  state_t                 state_q;
  logic [RES_WIDTH-1:0]   x_q, y_q, xres_q, yres_q;
  logic [DATA_WIDTH-1:0]  ramp_q, seed_q, dout_q;
  logic [BLANK_WIDTH-1:0] cnt_q, hb_q, vb_q;
  logic [1:0]             mode_q;
  logic                   douten_q, hsyn_q, vsyn_q, busy_q, done_q;

  logic                   cfg_ok, row_end, last_row, blank_done, frame_end, launch;
  logic [BLANK_WIDTH-1:0] hb_len;

  function automatic logic [DATA_WIDTH-1:0] pix_val(
    input logic [1:0]            m,
    input logic [DATA_WIDTH-1:0] sd,
    input logic [RES_WIDTH-1:0]  px,
    input logic [RES_WIDTH-1:0]  py,
    input logic [DATA_WIDTH-1:0] r
  );
    case (m)
      2'd0:    pix_val = r;
      2'd1:    pix_val = DATA_WIDTH'({py, px});
      2'd2:    pix_val = {DATA_WIDTH{px[3] ^ py[3]}};
      default: pix_val = sd;
    endcase
  endfunction

  always_comb begin
    cfg_ok     = (inXRes != '0) && (inYRes != '0);
    row_end    = (x_q == xres_q - RES_WIDTH'(1));
    last_row   = (y_q == yres_q - RES_WIDTH'(1));
    blank_done = (cnt_q == '0);
    hb_len     = (hb_q == '0) ? '0 : hb_q - BLANK_WIDTH'(1);
    // Last blanking cycle of the frame; a zero vBlank ends the frame straight out of HBLANK.
    frame_end  = en && !abort && blank_done &&
                 ((state_q == S_VBLANK) || (state_q == S_HBLANK && last_row && vb_q == '0));
    launch     = en && !abort && cfg_ok &&
                 ((state_q == S_IDLE && start) || (frame_end && cont));
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      ramp_q   <= '0;
      cnt_q    <= '0;
      xres_q   <= '0;
      yres_q   <= '0;
      hb_q     <= '0;
      vb_q     <= '0;
      mode_q   <= '0;
      seed_q   <= '0;
      dout_q   <= '0;
      douten_q <= 1'b0;
      hsyn_q   <= 1'b0;
      vsyn_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (abort) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      dout_q   <= '0;
      douten_q <= 1'b0;
      hsyn_q   <= 1'b0;
      vsyn_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (!en) begin
      // Position is held; the next enabled edge emits what would have come next.
      dout_q   <= '0;
      douten_q <= 1'b0;
      hsyn_q   <= 1'b0;
      vsyn_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      dout_q   <= '0;
      douten_q <= 1'b0;
      hsyn_q   <= 1'b0;
      vsyn_q   <= 1'b0;
      done_q   <= frame_end;
      if (launch) begin
        state_q <= S_VSYNC;
        busy_q  <= 1'b1;
        vsyn_q  <= 1'b1;
        x_q     <= '0;
        y_q     <= '0;
        ramp_q  <= '0;
        xres_q  <= inXRes;
        yres_q  <= inYRes;
        hb_q    <= hBlank;
        vb_q    <= vBlank;
        mode_q  <= mode;
        seed_q  <= seed;
      end else if (frame_end) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
          end
          S_VSYNC: begin
            state_q  <= S_PIX;
            douten_q <= 1'b1;
            dout_q   <= pix_val(mode_q, seed_q, x_q, y_q, ramp_q);
          end
          S_PIX: begin
            ramp_q <= ramp_q + DATA_WIDTH'(1);
            if (row_end) begin
              state_q <= S_HBLANK;
              cnt_q   <= hb_len;
              hsyn_q  <= 1'b1;
            end else begin
              x_q      <= x_q + RES_WIDTH'(1);
              douten_q <= 1'b1;
              dout_q   <= pix_val(mode_q, seed_q, x_q + RES_WIDTH'(1), y_q,
                                  ramp_q + DATA_WIDTH'(1));
            end
          end
          S_HBLANK: begin
            if (!blank_done) begin
              cnt_q <= cnt_q - BLANK_WIDTH'(1);
            end else if (!last_row) begin
              state_q  <= S_PIX;
              x_q      <= '0;
              y_q      <= y_q + RES_WIDTH'(1);
              douten_q <= 1'b1;
              dout_q   <= pix_val(mode_q, seed_q, '0, y_q + RES_WIDTH'(1), ramp_q);
            end else begin
              state_q <= S_VBLANK;
              cnt_q   <= vb_q - BLANK_WIDTH'(1);
            end
          end
          S_VBLANK: begin
            cnt_q <= cnt_q - BLANK_WIDTH'(1);
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dOut      = dout_q;
  assign dOutEn    = douten_q;
  assign oHsyn     = hsyn_q;
  assign oVsyn     = vsyn_q;
  assign busy      = busy_q;
  assign frameDone = done_q;

`ifdef STIM_GEN_CHKSUM_EN
  logic [31:0] acc_q, chk_q;

  // Accumulates from the registered pixel stream; the final pixel always lands before frame_end.
  always_ff @(posedge clka) begin
    if (rst) begin
      acc_q <= '0;
      chk_q <= '0;
    end else begin
      if (vsyn_q) begin
        acc_q <= '0;
      end else if (douten_q) begin
        acc_q <= acc_q + 32'(dout_q);
      end
      if (frame_end) begin
        chk_q <= acc_q;
      end
    end
  end

  assign chkSum = chk_q;
`else
  assign chkSum = 32'd0;
`endif

endmodule
